// File: rtl/spi_hsm_frame_ctrl_if.sv
// Bus bundle between the SPI slave / HSM core environment and spi_hsm_frame_ctrl.
// The slave modport is the framer's view and the master modport is the surrounding system's view.
interface spi_hsm_frame_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] i_rx_data;
    logic                  i_rx_valid;
    logic                  i_rx_error;
    logic [DATA_WIDTH-1:0] o_tx_data;
    logic                  o_tx_valid;
    logic                  i_tx_busy;
    logic                  o_cmd_valid;
    logic                  i_cmd_ready;
    logic [7:0]            o_cmd_opcode;
    logic [7:0]            o_cmd_len;
    logic [7:0]            i_buf_addr;
    logic [DATA_WIDTH-1:0] o_buf_data;
    logic [DATA_WIDTH-1:0] i_rsp_data;
    logic                  i_rsp_valid;
    logic                  i_rsp_last;
    logic                  o_rsp_ready;
    logic                  o_rx_drop;
    logic                  o_busy;

    modport slave (
        input  i_rx_data, i_rx_valid, i_rx_error, i_tx_busy, i_cmd_ready,
               i_buf_addr, i_rsp_data, i_rsp_valid, i_rsp_last,
        output o_tx_data, o_tx_valid, o_cmd_valid, o_cmd_opcode, o_cmd_len,
               o_buf_data, o_rsp_ready, o_rx_drop, o_busy
    );

    modport master (
        output i_rx_data, i_rx_valid, i_rx_error, i_tx_busy, i_cmd_ready,
               i_buf_addr, i_rsp_data, i_rsp_valid, i_rsp_last,
        input  o_tx_data, o_tx_valid, o_cmd_valid, o_cmd_opcode, o_cmd_len,
               o_buf_data, o_rsp_ready, o_rx_drop, o_busy
    );
endinterface

// File: rtl/spi_hsm_frame_ctrl.sv
// Command framer between the SPI slave and the HSM core: checks header/payload/XOR frames, returns status and response.
// Optional inter-word frame timeout is built only when V2X_FRAME_TIMEOUT_EN is defined.
module spi_hsm_frame_ctrl #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned MAX_PAYLOAD    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input logic                 i_sys_clk,
    input logic                 i_sys_rst,
    spi_hsm_frame_ctrl_if.slave bus
);
    localparam int unsigned AW    = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [7:0]            MAX_LEN  = 8'(MAX_PAYLOAD);
    localparam logic [DATA_WIDTH-1:0] STAT_OK  = 16'hA500;
    localparam logic [DATA_WIDTH-1:0] ERR_LEN  = 16'hEE01;
    localparam logic [DATA_WIDTH-1:0] ERR_CSUM = 16'hEE02;
    localparam logic [DATA_WIDTH-1:0] ERR_TOUT = 16'hEE03;
    localparam logic [DATA_WIDTH-1:0] ERR_RX   = 16'hEE04;

    if (DATA_WIDTH != 16 || MAX_PAYLOAD < 1 || MAX_PAYLOAD > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("spi_hsm_frame_ctrl: unsupported parameter set");
    end

    typedef enum logic [2:0] {IDLE, PAYLOAD, CSUM, ISSUE, STAT, RESP, ERR} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] xor_acc;
    logic [7:0]            cnt;
    logic [7:0]            opcode;
    logic [7:0]            len;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  cmd_valid;
    logic                  rx_drop;
    logic                  last_pending;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  tx_done;
    logic                  in_frame;
    logic                  buf_we;
    logic                  to_hit;

    assign tx_done  = tx_valid && !bus.i_tx_busy;
    assign in_frame = (state == PAYLOAD) || (state == CSUM);
    assign buf_we   = (state == PAYLOAD) && bus.i_rx_valid && !bus.i_rx_error;

`ifdef V2X_FRAME_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_cnt;

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            to_cnt <= '0;
        end else if (in_frame && !bus.i_rx_valid) begin
            to_cnt <= to_cnt + TW'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    assign to_hit = in_frame && !bus.i_rx_valid && (to_cnt == TO_LAST);
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state        <= IDLE;
            xor_acc      <= '0;
            cnt          <= '0;
            opcode       <= '0;
            len          <= '0;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            cmd_valid    <= 1'b0;
            rx_drop      <= 1'b0;
            last_pending <= 1'b0;
        end else begin
            rx_drop <= bus.i_rx_valid && (state inside {ISSUE, STAT, RESP, ERR});
            if (tx_done) tx_valid <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (bus.i_rx_valid) begin
                        opcode  <= bus.i_rx_data[15:8];
                        len     <= bus.i_rx_data[7:0];
                        xor_acc <= bus.i_rx_data;
                        cnt     <= '0;
                        if (bus.i_rx_data[7:0] > MAX_LEN) begin
                            state    <= ERR;
                            tx_data  <= ERR_LEN;
                            tx_valid <= 1'b1;
                        end else if (bus.i_rx_data[7:0] == 8'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    // An overrun strobe beats a coincident word, which is then not stored.
                    if (bus.i_rx_error) begin
                        state    <= ERR;
                        tx_data  <= ERR_RX;
                        tx_valid <= 1'b1;
                    end else if (to_hit) begin
                        state    <= ERR;
                        tx_data  <= ERR_TOUT;
                        tx_valid <= 1'b1;
                    end else if (bus.i_rx_valid) begin
                        xor_acc <= xor_acc ^ bus.i_rx_data;
                        cnt     <= cnt + 8'd1;
                        if (cnt == len - 8'd1) state <= CSUM;
                    end
                end
                CSUM: begin
                    if (bus.i_rx_error) begin
                        state    <= ERR;
                        tx_data  <= ERR_RX;
                        tx_valid <= 1'b1;
                    end else if (to_hit) begin
                        state    <= ERR;
                        tx_data  <= ERR_TOUT;
                        tx_valid <= 1'b1;
                    end else if (bus.i_rx_valid) begin
                        if (bus.i_rx_data == xor_acc) begin
                            state     <= ISSUE;
                            cmd_valid <= 1'b1;
                        end else begin
                            state    <= ERR;
                            tx_data  <= ERR_CSUM;
                            tx_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.i_cmd_ready) begin
                        cmd_valid    <= 1'b0;
                        state        <= STAT;
                        tx_data      <= STAT_OK;
                        tx_valid     <= 1'b1;
                        last_pending <= 1'b0;
                    end
                end
                STAT: begin
                    if (tx_done) state <= RESP;
                end
                RESP: begin
                    // The TX register is single entry, so a response is taken only while it is empty.
                    if (tx_done && last_pending) begin
                        state <= IDLE;
                    end else if (bus.i_rsp_valid && !tx_valid) begin
                        tx_data      <= bus.i_rsp_data;
                        tx_valid     <= 1'b1;
                        last_pending <= bus.i_rsp_last;
                    end
                end
                ERR: begin
                    if (tx_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (buf_we) mem[cnt[AW-1:0]] <= bus.i_rx_data;
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) buf_data <= '0;
        else           buf_data <= mem[bus.i_buf_addr[AW-1:0]];
    end

    assign bus.o_tx_data    = tx_data;
    assign bus.o_tx_valid   = tx_valid;
    assign bus.o_cmd_valid  = cmd_valid;
    assign bus.o_cmd_opcode = opcode;
    assign bus.o_cmd_len    = len;
    assign bus.o_buf_data   = buf_data;
    assign bus.o_rsp_ready  = (state == RESP) && !tx_valid;
    assign bus.o_rx_drop    = rx_drop;
    assign bus.o_busy       = (state != IDLE);
endmodule

// File: tb/tb_spi_hsm_frame_ctrl.sv
// Self-checking bench for spi_hsm_frame_ctrl: directed and randomized frames against a frame-level reference model.
// Define V2X_FRAME_TIMEOUT_EN for both bench and RTL to exercise the timeout path.
module tb_spi_hsm_frame_ctrl;
    localparam int unsigned MAXP = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_hsm_frame_ctrl_if #(.DATA_WIDTH(16)) bus ();

    spi_hsm_frame_ctrl #(
        .DATA_WIDTH    (16),
        .MAX_PAYLOAD   (MAXP),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .i_sys_clk(clk),
        .i_sys_rst(rst),
        .bus      (bus)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int n_cmd   = 0;
    int n_drop  = 0;

    logic [15:0] tx_q[$];
    logic [15:0] frm[$];
    logic [15:0] rsp[$];
    logic [15:0] exp_tx[$];
    bit          exp_good;

    // Transfer-level observers: TX handshakes, command handshakes, drop pulses.
    always @(posedge clk) begin
        if (!rst && bus.o_tx_valid && !bus.i_tx_busy) tx_q.push_back(bus.o_tx_data);
        if (!rst && bus.o_cmd_valid && bus.i_cmd_ready) n_cmd++;
        if (bus.o_rx_drop) n_drop++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w, input bit err = 1'b0);
        bus.i_rx_data  = w;
        bus.i_rx_valid = 1'b1;
        bus.i_rx_error = err;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
        bus.i_rx_error = 1'b0;
        tick($urandom_range(0, 2));
    endtask

    task automatic wait_cmd();
        int k = 0;
        while (!bus.o_cmd_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("cmd_valid_wait", 32'(k < 50), 32'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((bus.o_busy || bus.o_tx_valid) && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("idle_wait", 32'(k < 500), 32'd1);
    endtask

    task automatic send_rsp(input logic [15:0] w, input bit last);
        int k = 0;
        bus.i_rsp_data  = w;
        bus.i_rsp_last  = last;
        bus.i_rsp_valid = 1'b1;
        while (!bus.o_rsp_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("rsp_accept_wait", 32'(k < 200), 32'd1);
        @(negedge clk);
        bus.i_rsp_valid = 1'b0;
        bus.i_rsp_last  = 1'b0;
    endtask

    task automatic pulse_ready();
        bus.i_cmd_ready = 1'b1;
        @(negedge clk);
        bus.i_cmd_ready = 1'b0;
    endtask

    // Reference: what the SPI side must see for the frame in frm and responses in rsp.
    task automatic model_frame();
        int          n;
        logic [15:0] cs;
        logic [15:0] hdr;
        hdr = frm[0];
        n   = int'(hdr[7:0]);
        exp_tx.delete();
        exp_good = 1'b0;
        if (n > int'(MAXP)) begin
            exp_tx.push_back(16'hEE01);
        end else begin
            cs = 16'h0000;
            for (int i = 0; i <= n; i++) cs = cs ^ frm[i];
            if (frm[n + 1] == cs) begin
                exp_good = 1'b1;
                exp_tx.push_back(16'hA500);
                foreach (rsp[i]) exp_tx.push_back(rsp[i]);
            end else begin
                exp_tx.push_back(16'hEE02);
            end
        end
    endtask

    task automatic compare_tx();
        logic [31:0] got;
        check("tx_count", 32'(tx_q.size()), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size(); i++) begin
            got = (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hFFFF_FFFF;
            check("tx_word", got, 32'(exp_tx[i]));
        end
    endtask

    task automatic run_frame();
        int          n;
        int          c0;
        logic [15:0] hdr;
        model_frame();
        tx_q.delete();
        c0  = n_cmd;
        hdr = frm[0];
        n   = int'(hdr[7:0]);
        foreach (frm[i]) send_word(frm[i]);
        if (exp_good) begin
            wait_cmd();
            check("cmd_opcode", 32'(bus.o_cmd_opcode), 32'(hdr[15:8]));
            check("cmd_len", 32'(bus.o_cmd_len), 32'(hdr[7:0]));
            for (int i = 0; i < n; i++) begin
                bus.i_buf_addr = 8'(i);
                @(negedge clk);
                check("buf_data", 32'(bus.o_buf_data), 32'(frm[i + 1]));
            end
            pulse_ready();
            for (int i = 0; i < rsp.size(); i++) send_rsp(rsp[i], i == rsp.size() - 1);
        end
        wait_idle();
        check("cmd_count", 32'(n_cmd - c0), 32'(exp_good));
        compare_tx();
        frm.delete();
        rsp.delete();
    endtask

    initial begin
        logic [15:0] cs;
        logic [15:0] w;
        int          n;
        int          bad;

        rst             = 1'b1;
        bus.i_rx_data   = '0;
        bus.i_rx_valid  = 1'b0;
        bus.i_rx_error  = 1'b0;
        bus.i_tx_busy   = 1'b0;
        bus.i_cmd_ready = 1'b0;
        bus.i_buf_addr  = '0;
        bus.i_rsp_data  = '0;
        bus.i_rsp_valid = 1'b0;
        bus.i_rsp_last  = 1'b0;
        tick(3);
        check("rst_tx_valid", 32'(bus.o_tx_valid), 32'd0);
        check("rst_tx_data", 32'(bus.o_tx_data), 32'd0);
        check("rst_cmd_valid", 32'(bus.o_cmd_valid), 32'd0);
        check("rst_cmd_opcode", 32'(bus.o_cmd_opcode), 32'd0);
        check("rst_cmd_len", 32'(bus.o_cmd_len), 32'd0);
        check("rst_buf_data", 32'(bus.o_buf_data), 32'd0);
        check("rst_rsp_ready", 32'(bus.o_rsp_ready), 32'd0);
        check("rst_rx_drop", 32'(bus.o_rx_drop), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        rst = 1'b0;
        tick(2);

        // Good frame from the reference example.
        frm.push_back(16'h1002); frm.push_back(16'h1234);
        frm.push_back(16'hABCD); frm.push_back(16'hA9FB);
        rsp.push_back(16'h5555);
        run_frame();

        // Bad checksum.
        frm.push_back(16'h1002); frm.push_back(16'h1234);
        frm.push_back(16'hABCD); frm.push_back(16'h0000);
        run_frame();

        // Length overflow, then a zero-length frame.
        frm.push_back(16'h2021);
        run_frame();
        frm.push_back(16'h3000); frm.push_back(16'h3000);
        rsp.push_back(16'h0001);
        run_frame();

        // Maximum payload length is still accepted.
        cs = 16'h0520;
        frm.push_back(16'h0520);
        for (int i = 0; i < 32; i++) begin
            w = 16'($urandom);
            frm.push_back(w);
            cs = cs ^ w;
        end
        frm.push_back(cs);
        rsp.push_back(16'h0BEE);
        run_frame();

        // Backpressure while a response word is pending.
        frm.push_back(16'h4003); frm.push_back(16'h0011);
        frm.push_back(16'h0022); frm.push_back(16'h0033);
        frm.push_back(16'h4003 ^ 16'h0011 ^ 16'h0022 ^ 16'h0033);
        rsp.push_back(16'hC001); rsp.push_back(16'hC002); rsp.push_back(16'hC003);
        model_frame();
        tx_q.delete();
        foreach (frm[i]) send_word(frm[i]);
        wait_cmd();
        pulse_ready();
        send_rsp(16'hC001, 1'b0);
        bus.i_tx_busy   = 1'b1;
        bus.i_rsp_data  = 16'hC002;
        bus.i_rsp_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.o_tx_valid || bus.o_tx_data != 16'hC001 || bus.o_rsp_ready) bad++;
        end
        check("bp_hold_cycles_bad", 32'(bad), 32'd0);
        check("bp_tx_q_size", 32'(tx_q.size()), 32'd1);
        bus.i_tx_busy = 1'b0;
        send_rsp(16'hC002, 1'b0);
        send_rsp(16'hC003, 1'b1);
        wait_idle();
        compare_tx();
        frm.delete();
        rsp.delete();

        // Word arriving while the command is pending is dropped with a one-cycle pulse.
        tx_q.delete();
        send_word(16'h5001); send_word(16'h0042); send_word(16'h5001 ^ 16'h0042);
        wait_cmd();
        n = n_drop;
        bus.i_rx_data  = 16'hDEAD;
        bus.i_rx_valid = 1'b1;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
        check("drop_pulse_hi", 32'(bus.o_rx_drop), 32'd1);
        @(negedge clk);
        check("drop_pulse_lo", 32'(bus.o_rx_drop), 32'd0);
        check("drop_count", 32'(n_drop - n), 32'd1);
        check("drop_cmd_still_valid", 32'(bus.o_cmd_valid), 32'd1);
        pulse_ready();
        send_rsp(16'h0D0D, 1'b1);
        wait_idle();
        exp_tx.delete();
        exp_tx.push_back(16'hA500);
        exp_tx.push_back(16'h0D0D);
        compare_tx();

        // Overrun in the middle of the payload.
        tx_q.delete();
        send_word(16'h1002); send_word(16'h1234);
        bus.i_rx_error = 1'b1;
        @(negedge clk);
        bus.i_rx_error = 1'b0;
        wait_idle();
        exp_tx.delete();
        exp_tx.push_back(16'hEE04);
        compare_tx();

        // Overrun coinciding with a correct checksum word: the error wins.
        tx_q.delete();
        n = n_cmd;
        send_word(16'h6001); send_word(16'h0077);
        send_word(16'h6001 ^ 16'h0077, 1'b1);
        wait_idle();
        check("err_vs_csum_no_cmd", 32'(n_cmd - n), 32'd0);
        compare_tx();

        // Reset mid-frame and with an error word stuck in the TX register.
        tx_q.delete();
        send_word(16'h7003); send_word(16'h1111);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(bus.o_busy), 32'd0);
        check("midrst_tx_valid", 32'(bus.o_tx_valid), 32'd0);
        bus.i_tx_busy = 1'b1;
        send_word(16'h2021);
        check("stuck_tx_valid", 32'(bus.o_tx_valid), 32'd1);
        check("stuck_tx_data", 32'(bus.o_tx_data), 32'hEE01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.i_tx_busy = 1'b0;
        check("txrst_tx_valid", 32'(bus.o_tx_valid), 32'd0);
        check("txrst_busy", 32'(bus.o_busy), 32'd0);
        tick(3);
        check("txrst_nothing_sent", 32'(tx_q.size()), 32'd0);

        // Silence after a header.
        tx_q.delete();
        bus.i_rx_data  = 16'h1001;
        bus.i_rx_valid = 1'b1;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
`ifdef V2X_FRAME_TIMEOUT_EN
        tick(49);
        check("tout_not_yet", 32'(bus.o_tx_valid), 32'd0);
        tick(1);
        check("tout_tx_valid", 32'(bus.o_tx_valid), 32'd1);
        check("tout_tx_data", 32'(bus.o_tx_data), 32'hEE03);
        wait_idle();
        exp_tx.delete();
        exp_tx.push_back(16'hEE03);
        compare_tx();
`else
        tick(200);
        check("notout_busy", 32'(bus.o_busy), 32'd1);
        check("notout_tx_valid", 32'(bus.o_tx_valid), 32'd0);
        send_word(16'h00AA);
        send_word(16'h1001 ^ 16'h00AA);
        wait_cmd();
        check("notout_cmd_len", 32'(bus.o_cmd_len), 32'd1);
        pulse_ready();
        send_rsp(16'h7777, 1'b1);
        wait_idle();
        exp_tx.delete();
        exp_tx.push_back(16'hA500);
        exp_tx.push_back(16'h7777);
        compare_tx();
`endif

        // Randomized frames: mixed lengths, occasional overflow and corrupted checksums.
        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 5) == 0) n = $urandom_range(MAXP + 1, 255);
            else                           n = $urandom_range(0, 6);
            w = {8'($urandom), 8'(n)};
            frm.push_back(w);
            if (n <= int'(MAXP)) begin
                cs = w;
                for (int i = 0; i < n; i++) begin
                    w = 16'($urandom);
                    frm.push_back(w);
                    cs = cs ^ w;
                end
                if ($urandom_range(0, 3) == 0) cs = cs ^ (16'h0001 << $urandom_range(0, 15));
                frm.push_back(cs);
                for (int i = 0; i < int'($urandom_range(1, 3)); i++) rsp.push_back(16'($urandom));
            end
            run_frame();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
